// File: rtl/l1_dcache_if.sv
// l1_dcache_if: bundles every signal of the L1 data cache boundary.
//   cpu_*      core load/store request and response
//   mem_*      word port towards data_mem (fills and write-throughs)
//   snoop_*    invalidate requests coming from other caches
//   bus_wr_*   write broadcast seen by the other caches
//   state_dbg  current cache FSM state, for observation only
// Modports: slave = the cache itself, master = core/memory/bus side.
//
// Handshake: cpu_req is held high with address, data and controls stable
// until the cycle in which cpu_ready is high; that cycle completes the
// request, and cpu_rdata is meaningful only in that cycle (0 otherwise).
interface l1_dcache_if #(
    parameter int n = 32
);
    logic          cpu_req;
    logic [n-3:0]  cpu_address;
    logic [31:0]   cpu_wdata;
    logic [2:0]    cpu_load_control;
    logic [1:0]    cpu_store_control;
    logic [31:0]   cpu_rdata;
    logic          cpu_ready;
    logic [n-3:0]  mem_address;
    logic [31:0]   mem_wdata;
    logic [2:0]    mem_load_control;
    logic [1:0]    mem_store_control;
    logic [31:0]   mem_rdata;
    logic          snoop_inv;
    logic [n-3:0]  snoop_address;
    logic          bus_wr_valid;
    logic [n-3:0]  bus_wr_address;
    logic [1:0]    state_dbg;

    modport slave (
        input  cpu_req, cpu_address, cpu_wdata, cpu_load_control, cpu_store_control,
        input  mem_rdata, snoop_inv, snoop_address,
        output cpu_rdata, cpu_ready, mem_address, mem_wdata, mem_load_control,
        output mem_store_control, bus_wr_valid, bus_wr_address, state_dbg
    );

    modport master (
        output cpu_req, cpu_address, cpu_wdata, cpu_load_control, cpu_store_control,
        output mem_rdata, snoop_inv, snoop_address,
        input  cpu_rdata, cpu_ready, mem_address, mem_wdata, mem_load_control,
        input  mem_store_control, bus_wr_valid, bus_wr_address, state_dbg
    );
endinterface

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-through, no-write-allocate L1 data cache
// with one 32-bit word per line. Load hits complete in the request cycle,
// load misses take one FILL cycle from data_mem, stores always write through
// in one WRITE cycle and update the line only when it hits.
// Ports:
//   clk    single clock, all state changes on posedge
//   reset  asynchronous, active-high; clears valid bits and FSM
//   port   l1_dcache_if.slave (core request/response, data_mem port,
//          snoop invalidate input, write broadcast output, state_dbg)
module l1_dcache #(
    parameter int n          = 32,
    parameter int index_bits = 4
) (
    input  logic         clk,
    input  logic         reset,
    l1_dcache_if.slave   port
);
    localparam int lines = 2 ** index_bits;
    localparam int tag_w = n - 2 - index_bits;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [lines-1:0] valid;
    logic [tag_w-1:0] tag_q  [lines];
    logic [31:0]      data_q [lines];

    logic [index_bits-1:0] idx, s_idx;
    logic [tag_w-1:0]      tag_in, s_tag;
    logic                  hit, is_load, is_store;
    logic                  snoop_hit, snoop_same;
    logic                  line_fill, line_write;
    logic                  ready;
    logic [31:0]           rdata, line_word, store_word;
    logic [2:0]            mlc;
    logic [1:0]            msc;
    logic                  bus_wr;

    assign idx      = port.cpu_address[index_bits-1:0];
    assign tag_in   = port.cpu_address[n-3:index_bits];
    assign s_idx    = port.snoop_address[index_bits-1:0];
    assign s_tag    = port.snoop_address[n-3:index_bits];
    assign hit      = valid[idx] && (tag_q[idx] == tag_in);
    assign is_store = (port.cpu_store_control != 2'b00);
    assign is_load  = (port.cpu_load_control >= 3'd1) && (port.cpu_load_control <= 3'd5);
    assign line_word = data_q[idx];

    // Snoop against the resident line; snoop_same catches the line that is
    // being (re)written this very cycle so the invalidate is not lost.
    assign snoop_hit  = port.snoop_inv && valid[s_idx] && (tag_q[s_idx] == s_tag);
    assign snoop_same = port.snoop_inv && (port.snoop_address == port.cpu_address);

    function automatic logic [31:0] load_ext(input logic [2:0] lc, input logic [31:0] w);
        case (lc)
            3'd1:    load_ext = w;
            3'd2:    load_ext = {{16{w[15]}}, w[15:0]};
            3'd3:    load_ext = {16'b0, w[15:0]};
            3'd4:    load_ext = {{24{w[7]}}, w[7:0]};
            3'd5:    load_ext = {24'b0, w[7:0]};
            default: load_ext = 32'b0;
        endcase
    endfunction

    // Same formatting data_mem applies, so the line stays equal to memory.
    always_comb begin
        case (port.cpu_store_control)
            2'b10:   store_word = {16'b0, port.cpu_wdata[15:0]};
            2'b11:   store_word = {24'b0, port.cpu_wdata[7:0]};
            default: store_word = port.cpu_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        ready      = 1'b0;
        rdata      = 32'b0;
        mlc        = 3'b000;
        msc        = 2'b00;
        bus_wr     = 1'b0;
        line_fill  = 1'b0;
        line_write = 1'b0;
        case (state)
            IDLE: begin
                if (port.cpu_req) begin
                    if (is_store) begin
                        state_nx = WRITE;
                    end else if (is_load) begin
                        if (hit) begin
                            ready = 1'b1;
                            rdata = load_ext(port.cpu_load_control, line_word);
                        end else begin
                            state_nx = FILL;
                        end
                    end else begin
                        ready = 1'b1;
                    end
                end
            end
            FILL: begin
                mlc       = 3'b001;
                line_fill = 1'b1;
                state_nx  = IDLE;
            end
            WRITE: begin
                msc        = port.cpu_store_control;
                bus_wr     = 1'b1;
                ready      = 1'b1;
                line_write = hit;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (reset) begin
            ready = 1'b0;
            rdata = 32'b0;
        end
    end

    // Later assignment to valid[idx] overrides the generic snoop clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (snoop_hit) valid[s_idx] <= 1'b0;
            if (line_fill || line_write) valid[idx] <= !snoop_same;
        end
    end

    always_ff @(posedge clk) begin
        if (line_fill) begin
            data_q[idx] <= port.mem_rdata;
            tag_q[idx]  <= tag_in;
        end else if (line_write) begin
            data_q[idx] <= store_word;
        end
    end

    assign port.cpu_ready         = ready;
    assign port.cpu_rdata         = rdata;
    assign port.mem_address       = port.cpu_address;
    assign port.mem_wdata         = port.cpu_wdata;
    assign port.mem_load_control  = mlc;
    assign port.mem_store_control = msc;
    assign port.bus_wr_valid      = bus_wr;
    assign port.bus_wr_address    = port.cpu_address;
    assign port.state_dbg         = state;
endmodule

// File: tb/tb_l1_dcache.sv
module tb_l1_dcache;
    logic clk;
    logic reset;

    l1_dcache_if #(.n(32)) dif ();

    l1_dcache #(.n(32), .index_bits(4)) dut (
        .clk   (clk),
        .reset (reset),
        .port  (dif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data_mem model ----------------
    logic [31:0] dmem  [256];
    logic [31:0] ref_m [256];

    function automatic logic [31:0] ext_ld(input logic [2:0] lc, input logic [31:0] w);
        case (lc)
            3'd1:    ext_ld = w;
            3'd2:    ext_ld = {{16{w[15]}}, w[15:0]};
            3'd3:    ext_ld = {16'b0, w[15:0]};
            3'd4:    ext_ld = {{24{w[7]}}, w[7:0]};
            3'd5:    ext_ld = {24'b0, w[7:0]};
            default: ext_ld = 32'b0;
        endcase
    endfunction

    function automatic logic [31:0] fmt_st(input logic [1:0] sc, input logic [31:0] w);
        case (sc)
            2'b10:   fmt_st = {16'b0, w[15:0]};
            2'b11:   fmt_st = {24'b0, w[7:0]};
            default: fmt_st = w;
        endcase
    endfunction

    assign dif.mem_rdata = dmem[dif.mem_address[7:0]];

    always @(posedge clk) begin
        if (dif.mem_store_control != 2'b00)
            dmem[dif.mem_address[7:0]] <= fmt_st(dif.mem_store_control, dif.mem_wdata);
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    int          lat;
    int          fill_cnt;
    logic [1:0]  st_seen;
    logic        bus_seen;
    logic [31:0] rd;

    // Runs one request; snoop_cyc != 0 pulses a snoop on the same address
    // during that cycle of the request.
    task automatic issue(input logic [29:0] a, input logic [2:0] lc, input logic [1:0] sc,
                         input logic [31:0] wd, input int snoop_cyc);
        bit done;
        int cyc;
        @(negedge clk);
        dif.cpu_req           = 1'b1;
        dif.cpu_address       = a;
        dif.cpu_wdata         = wd;
        dif.cpu_load_control  = lc;
        dif.cpu_store_control = sc;
        done = 1'b0; cyc = 0; fill_cnt = 0; st_seen = 2'b00; bus_seen = 1'b0; rd = 32'b0;
        while (!done && cyc < 20) begin
            cyc++;
            dif.snoop_inv     = (cyc == snoop_cyc);
            dif.snoop_address = a;
            #1;
            if (dif.mem_load_control == 3'b001) fill_cnt++;
            if (dif.mem_store_control != 2'b00) st_seen = dif.mem_store_control;
            if (dif.bus_wr_valid) bus_seen = 1'b1;
            if (dif.cpu_ready) begin
                done = 1'b1;
                rd   = dif.cpu_rdata;
            end
            @(posedge clk);
            #1;
            if (!done) @(negedge clk);
        end
        dif.cpu_req           = 1'b0;
        dif.snoop_inv         = 1'b0;
        dif.cpu_load_control  = 3'b000;
        dif.cpu_store_control = 2'b00;
        lat = cyc;
        if (!done) check_eq("req_timeout", 32'(done), 32'd1);
        if (sc != 2'b00) ref_m[a[7:0]] = fmt_st(sc, wd);
    endtask

    task automatic snoop_pulse(input logic [29:0] a);
        @(negedge clk);
        dif.snoop_inv     = 1'b1;
        dif.snoop_address = a;
        @(negedge clk);
        dif.snoop_inv     = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic        rv [16];
    logic [25:0] rt [16];

    initial begin
        for (int i = 0; i < 256; i++) begin
            dmem[i]  = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};
            ref_m[i] = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};
        end
        dmem[5]  = 32'hDEADBEEF;
        ref_m[5] = 32'hDEADBEEF;

        reset = 1'b1;
        dif.cpu_req = 1'b0; dif.cpu_address = '0; dif.cpu_wdata = '0;
        dif.cpu_load_control = 3'b000; dif.cpu_store_control = 2'b00;
        dif.snoop_inv = 1'b0; dif.snoop_address = '0;

        // reset state, with a no-op request held to show ready is masked
        #12;
        dif.cpu_req = 1'b1;
        #1;
        check_eq("rst_ready", 32'(dif.cpu_ready), 32'd0);
        check_eq("rst_rdata", dif.cpu_rdata, 32'd0);
        check_eq("rst_mlc", 32'(dif.mem_load_control), 32'd0);
        check_eq("rst_msc", 32'(dif.mem_store_control), 32'd0);
        check_eq("rst_bus", 32'(dif.bus_wr_valid), 32'd0);
        check_eq("rst_state", 32'(dif.state_dbg), 32'd0);
        dif.cpu_req = 1'b0;
        @(posedge clk); #1 reset = 1'b0;

        // 1: cold load miss
        issue(30'h05, 3'd1, 2'b00, 32'h0, 0);
        check_eq("t1_lat", lat, 3);
        check_eq("t1_fill", fill_cnt, 1);
        check_eq("t1_rdata", rd, 32'hDEADBEEF);

        // 2: hits with extension
        issue(30'h05, 3'd1, 2'b00, 32'h0, 0);
        check_eq("t2_lw_lat", lat, 1);
        check_eq("t2_lw_fill", fill_cnt, 0);
        check_eq("t2_lw", rd, 32'hDEADBEEF);
        issue(30'h05, 3'd4, 2'b00, 32'h0, 0);
        check_eq("t2_lb", rd, 32'hFFFFFFEF);
        issue(30'h05, 3'd5, 2'b00, 32'h0, 0);
        check_eq("t2_lbu", rd, 32'h000000EF);
        issue(30'h05, 3'd2, 2'b00, 32'h0, 0);
        check_eq("t2_lh", rd, 32'hFFFFBEEF);
        issue(30'h05, 3'd3, 2'b00, 32'h0, 0);
        check_eq("t2_lhu", rd, 32'h0000BEEF);
        check_eq("t2_lhu_lat", lat, 1);

        // 3: SH hit
        issue(30'h05, 3'd0, 2'b10, 32'h12348001, 0);
        check_eq("t3_lat", lat, 2);
        check_eq("t3_msc", 32'(st_seen), 32'd2);
        check_eq("t3_bus", 32'(bus_seen), 32'd1);
        check_eq("t3_dmem", dmem[5], 32'h00008001);
        issue(30'h05, 3'd1, 2'b00, 32'h0, 0);
        check_eq("t3_lw_lat", lat, 1);
        check_eq("t3_lw", rd, 32'h00008001);

        // 4: SW miss on same index, no allocate
        issue(30'h15, 3'd0, 2'b01, 32'hCAFEF00D, 0);
        check_eq("t4_sw_lat", lat, 2);
        check_eq("t4_dmem", dmem[8'h15], 32'hCAFEF00D);
        issue(30'h05, 3'd1, 2'b00, 32'h0, 0);
        check_eq("t4_keep_lat", lat, 1);
        check_eq("t4_keep", rd, 32'h00008001);
        issue(30'h15, 3'd1, 2'b00, 32'h0, 0);
        check_eq("t4_evict_lat", lat, 3);
        check_eq("t4_evict", rd, 32'hCAFEF00D);
        issue(30'h05, 3'd1, 2'b00, 32'h0, 0);
        check_eq("t4_refill_lat", lat, 3);
        check_eq("t4_refill", rd, 32'h00008001);

        // 5: snoops
        snoop_pulse(30'h25);
        issue(30'h05, 3'd1, 2'b00, 32'h0, 0);
        check_eq("t5_othertag_lat", lat, 1);
        snoop_pulse(30'h05);
        issue(30'h05, 3'd1, 2'b00, 32'h0, 0);
        check_eq("t5_snoop_lat", lat, 3);
        check_eq("t5_snoop_rd", rd, 32'h00008001);
        issue(30'h05, 3'd0, 2'b01, 32'h11223344, 2);
        check_eq("t5_sw_lat", lat, 2);
        issue(30'h05, 3'd1, 2'b00, 32'h0, 0);
        check_eq("t5_wsnoop_lat", lat, 3);
        check_eq("t5_wsnoop_rd", rd, 32'h11223344);
        snoop_pulse(30'h05);
        issue(30'h05, 3'd1, 2'b00, 32'h0, 2);
        check_eq("t5_fsnoop_lat", lat, 5);
        check_eq("t5_fsnoop_fills", fill_cnt, 2);
        check_eq("t5_fsnoop_rd", rd, 32'h11223344);
        issue(30'h05, 3'd1, 2'b00, 32'h0, 0);
        check_eq("t5_after_lat", lat, 1);

        // 6: reset during FILL
        @(negedge clk);
        dif.cpu_req = 1'b1; dif.cpu_address = 30'h06;
        dif.cpu_load_control = 3'd1; dif.cpu_store_control = 2'b00;
        @(posedge clk);
        #1;
        check_eq("t6_in_fill", 32'(dif.mem_load_control), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_rst_mlc", 32'(dif.mem_load_control), 32'd0);
        check_eq("t6_rst_ready", 32'(dif.cpu_ready), 32'd0);
        check_eq("t6_rst_state", 32'(dif.state_dbg), 32'd0);
        dif.cpu_req = 1'b0; dif.cpu_load_control = 3'd0;
        @(posedge clk); #1 reset = 1'b0;
        issue(30'h05, 3'd1, 2'b00, 32'h0, 0);
        check_eq("t6_l5_lat", lat, 3);
        check_eq("t6_l5", rd, 32'h11223344);
        issue(30'h06, 3'd1, 2'b00, 32'h0, 0);
        check_eq("t6_l6_lat", lat, 3);
        check_eq("t6_l6", rd, ref_m[6]);

        // random ops against reference memory and line-state model
        for (int i = 0; i < 16; i++) begin
            rv[i] = 1'b0;
            rt[i] = '0;
        end
        rv[5] = 1'b1;
        rv[6] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            logic [29:0] a;
            logic [2:0]  lc;
            logic [1:0]  sc;
            logic [31:0] wd;
            int          kind, exp_lat;
            a    = 30'($urandom_range(0, 63));
            wd   = $urandom;
            kind = $urandom_range(0, 9);
            lc   = 3'd0;
            sc   = 2'b00;
            if (kind <= 4)      lc = 3'(kind + 1);
            else if (kind <= 7) sc = 2'(kind - 4);
            else                lc = (kind == 8) ? 3'd6 : 3'd0;
            if (sc != 2'b00) begin
                exp_q.push_back(32'h0);
                exp_lat = 2;
            end else if (lc >= 3'd1 && lc <= 3'd5) begin
                exp_q.push_back(ext_ld(lc, ref_m[a[7:0]]));
                exp_lat = (rv[a[3:0]] && rt[a[3:0]] == a[29:4]) ? 1 : 3;
                rv[a[3:0]] = 1'b1;
                rt[a[3:0]] = a[29:4];
            end else begin
                exp_q.push_back(32'h0);
                exp_lat = 1;
            end
            issue(a, lc, sc, wd, 0);
            check_eq("rnd_rdata", rd, exp_q.pop_front());
            check_eq("rnd_lat", lat, exp_lat);
        end
        for (int i = 0; i < 64; i++)
            check_eq("rnd_mem", dmem[i], ref_m[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
